// File: rtl/im_request_queue.sv
// Intersection-manager request queue.
// Four approach lanes raise request levels; each rising edge captures the
// vehicle's identity, position, velocity and a timestamp into a per-lane
// holding register. A round-robin arbiter moves held requests into a
// first-word-fall-through FIFO, subject to an admission limit on the number
// of vehicles currently inside the intersection.
//
// Handshake (out_valid/out_ready): out_valid is high whenever the FIFO holds
// an entry and the out_* fields show that head entry. A transfer happens on a
// rising clk edge where out_valid and out_ready are both high. While out_valid
// is high and out_ready is low the head entry and out_* stay unchanged. When
// out_valid is low, the out_* fields carry no meaning.
module im_request_queue #(
  parameter int W        = 11,
  parameter int DEPTH    = 8,
  parameter int MAX_CARS = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     lane_req,
  input  logic [4*W-1:0] lane_car_id,
  input  logic [4*W-1:0] lane_x0,
  input  logic [4*W-1:0] lane_v0,
  input  logic [W-1:0]   global_time,
  input  logic           finish,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_car_id,
  output logic [W-1:0]   out_x0,
  output logic [W-1:0]   out_v0,
  output logic [W-1:0]   out_t0,
  output logic [1:0]     out_lane,
  output logic [3:0]     cars,
  output logic           overflow,
  output logic [7:0]     drop_count
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [3:0] MAX_CARS_L = 4'(MAX_CARS);

  typedef struct packed {
    logic [1:0]   lane;
    logic [W-1:0] car_id;
    logic [W-1:0] x0;
    logic [W-1:0] v0;
    logic [W-1:0] t0;
  } entry_t;

  logic [3:0]  sync1, sync2;
  logic [3:0]  lane_edge;
  logic [3:0]  pending;
  entry_t      hold [4];
  logic [1:0]  rr_ptr;
  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        pop, push, can_grant, found;
  logic [1:0]  grant_lane, idx;
  logic [3:0]  grant_mask, capture_mask, drop_mask;
  logic [2:0]  drop_num;
  logic [8:0]  drop_sum;
  logic        fin_eff;
  entry_t      head;

  // Two-flop synchronizer on the lane request levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= lane_req;
      sync2 <= sync1;
    end
  end

  assign lane_edge = sync1 & ~sync2;

  // FIFO status, decoded from the extra pointer MSB.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid & out_ready;
  // A slot frees up in the same cycle as a pop, so a full FIFO can still accept.
  assign can_grant  = (!fifo_full || pop) && (cars < MAX_CARS_L);

  // Round-robin search over pending lanes starting at rr_ptr; the loop runs
  // from the farthest offset down so the nearest pending lane wins.
  always_comb begin
    found      = 1'b0;
    grant_lane = rr_ptr;
    idx        = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (pending[idx]) begin
        found      = 1'b1;
        grant_lane = idx;
      end
    end
    push       = found & can_grant;
    grant_mask = push ? (4'b0001 << grant_lane) : 4'b0000;
  end

  // A lane being granted this cycle frees its holding register, so a new edge
  // on it is captured rather than dropped.
  assign capture_mask = lane_edge & (~pending | grant_mask);
  assign drop_mask    = lane_edge & pending & ~grant_mask;

  // Count of requests dropped this cycle, added to the saturating counter.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < 4; i++) begin
      drop_num = drop_num + 3'(drop_mask[i]);
    end
    drop_sum = {1'b0, drop_count} + 9'(drop_num);
  end

  // Per-lane pending flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | capture_mask;
    end
  end

  // Holding registers load on capture; reset leaves their contents alone.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (capture_mask[n]) begin
        hold[n].lane   <= 2'(n);
        hold[n].car_id <= lane_car_id[n*W +: W];
        hold[n].x0     <= lane_x0[n*W +: W];
        hold[n].v0     <= lane_v0[n*W +: W];
        hold[n].t0     <= global_time;
      end
    end
  end

  // Round-robin pointer moves just past the lane that was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= grant_lane + 2'd1;
    end
  end

  // FIFO storage write; storage is not cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= hold[grant_lane];
    end
  end

  // FIFO read and write pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Head entry falls through combinationally from storage.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_lane   = head.lane;
  assign out_car_id = head.car_id;
  assign out_x0     = head.x0;
  assign out_v0     = head.v0;
  assign out_t0     = head.t0;

  // Vehicles inside the intersection: up on push, down on finish, never below 0.
  assign fin_eff = finish && (cars != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cars <= '0;
    end else begin
      case ({push, fin_eff})
        2'b10:   cars <= cars + 4'd1;
        2'b01:   cars <= cars - 4'd1;
        default: cars <= cars;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (|drop_mask) overflow <= 1'b1;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_im_request_queue.sv
// Bench for im_request_queue: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a queue-based model.
module tb_im_request_queue;

  localparam int W     = 11;
  localparam int DEPTH = 8;
  localparam int MAXC  = 12;
  localparam int EW    = 2 + 4*W;

  logic           clk;
  logic           rst;
  logic [3:0]     lane_req;
  logic [4*W-1:0] lane_car_id, lane_x0, lane_v0;
  logic [W-1:0]   global_time;
  logic           finish;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_car_id, out_x0, out_v0, out_t0;
  logic [1:0]     out_lane;
  logic [3:0]     cars;
  logic           overflow;
  logic [7:0]     drop_count;

  im_request_queue #(.W(W), .DEPTH(DEPTH), .MAX_CARS(MAXC)) dut (
    .clk(clk), .rst(rst), .lane_req(lane_req),
    .lane_car_id(lane_car_id), .lane_x0(lane_x0), .lane_v0(lane_v0),
    .global_time(global_time), .finish(finish),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_car_id(out_car_id), .out_x0(out_x0), .out_v0(out_v0), .out_t0(out_t0),
    .out_lane(out_lane), .cars(cars), .overflow(overflow), .drop_count(drop_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit time_run = 1'b1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queued entries in delivery order, packed {lane, car_id, x0, v0, t0}.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_hold [4];
  logic [3:0]    seen1, seen2;   // lane levels observed one and two clocks ago
  logic [3:0]    m_pend;
  int            m_rr, m_cars, m_drops;
  bit            m_ovf;
  bit            model_on = 1'b0;

  task automatic model_step();
    bit rise [4];
    bit pop_m, fin_m;
    int g;
    if (rst) begin
      model_on = 1'b1;
      exp_q.delete();
      seen1 = '0; seen2 = '0; m_pend = '0;
      m_rr = 0; m_cars = 0; m_drops = 0; m_ovf = 1'b0;
      return;
    end
    if (!model_on) return;
    for (int n = 0; n < 4; n++) rise[n] = seen1[n] && !seen2[n];
    pop_m = (exp_q.size() > 0) && out_ready;
    g = -1;
    if ((exp_q.size() < DEPTH || pop_m) && m_cars < MAXC) begin
      for (int off = 0; off < 4; off++) begin
        if (g < 0 && m_pend[(m_rr + off) % 4]) g = (m_rr + off) % 4;
      end
    end
    if (pop_m) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back(m_hold[g]);
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % 4;
    end
    for (int n = 0; n < 4; n++) begin
      if (rise[n]) begin
        if (m_pend[n]) begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end else begin
          logic [1:0] ln;
          ln = 2'(n);
          m_pend[n] = 1'b1;
          m_hold[n] = {ln, lane_car_id[n*W +: W], lane_x0[n*W +: W],
                       lane_v0[n*W +: W], global_time};
        end
      end
    end
    fin_m = finish && (m_cars > 0);
    m_cars = m_cars + ((g >= 0) ? 1 : 0) - (fin_m ? 1 : 0);
    seen2 = seen1;
    seen1 = lane_req;
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(posedge clk) begin
    model_step();
    #2;
    if (model_on) begin
      chk("out_valid", out_valid, (exp_q.size() != 0) ? 1 : 0);
      if (exp_q.size() != 0 && out_valid) begin
        logic [EW-1:0] h;
        h = exp_q[0];
        chk("out_lane",   out_lane,   h[EW-1 -: 2]);
        chk("out_car_id", out_car_id, h[4*W-1 -: W]);
        chk("out_x0",     out_x0,     h[3*W-1 -: W]);
        chk("out_v0",     out_v0,     h[2*W-1 -: W]);
        chk("out_t0",     out_t0,     h[W-1:0]);
      end
      chk("cars",       cars,       m_cars);
      chk("overflow",   overflow,   m_ovf);
      chk("drop_count", drop_count, m_drops);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (time_run) global_time = global_time + 1'b1;
    end
  endtask

  task automatic set_lane(input int n, input int car, input int x, input int v);
    lane_car_id[n*W +: W] = W'(car);
    lane_x0[n*W +: W]     = W'(x);
    lane_v0[n*W +: W]     = W'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; lane_req = '0; finish = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // One-cycle-high request pulse followed by one low cycle.
  task automatic pulse_req(input int n, input int car);
    set_lane(n, car, car + 1, car + 2);
    lane_req[n] = 1'b1;
    tick();
    lane_req[n] = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; lane_req = '0; finish = 1'b0; out_ready = 1'b0;
    lane_car_id = '0; lane_x0 = '0; lane_v0 = '0; global_time = '0;
    tick(2);
    do_reset();

    // Single request on lane 2, exact latency and captured timestamp.
    out_ready = 1'b1;
    time_run = 1'b0;
    global_time = 11'd37;
    set_lane(2, 5, 100, 20);
    lane_req[2] = 1'b1;
    tick(2);
    chk("lat_valid_early", out_valid, 0);
    tick();
    chk("lat_valid",  out_valid, 1);
    chk("lat_lane",   out_lane, 2);
    chk("lat_t0",     out_t0, 37);
    chk("lat_car",    out_car_id, 5);
    chk("lat_x0",     out_x0, 100);
    chk("lat_v0",     out_v0, 20);
    chk("lat_cars",   cars, 1);
    lane_req = '0;
    time_run = 1'b1;
    tick(3);

    // All four lanes at once from rr_ptr=0: delivered in lane order.
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) set_lane(n, 10 + n, 0, 0);
    lane_req = 4'hF;
    tick(6);
    lane_req = '0;
    chk("rr_cars", cars, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_lane", out_lane, k);
      chk("rr_car",  out_car_id, 10 + k);
      tick();
    end
    // Pointer is back at 0, so lane 0 beats lane 3.
    set_lane(0, 20, 0, 0);
    set_lane(3, 23, 0, 0);
    lane_req = 4'b1001;
    tick(3);
    chk("rr_wrap_first", out_lane, 0);
    tick();
    chk("rr_wrap_second", out_lane, 3);
    lane_req = '0;
    tick(3);

    // Fill the FIFO, hold the 9th, drop a re-request, then drain.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) pulse_req((k + 1) % 4, 50 + k);
    tick(4);
    chk("full_cars",  cars, 8);
    chk("full_valid", out_valid, 1);
    pulse_req(1, 99);
    tick(2);
    chk("drop_ovf",   overflow, 1);
    chk("drop_count", drop_count, 1);
    chk("drop_cars",  cars, 8);
    out_ready = 1'b1;
    chk("pop_head", out_car_id, 50);
    tick();
    out_ready = 1'b0;
    chk("pop_push_cars", cars, 9);
    chk("pop_new_head",  out_car_id, 51);
    tick();
    out_ready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      chk("drain_car", out_car_id, 50 + k);
      tick();
    end
    chk("drain_empty", out_valid, 0);
    // Finish pulses beyond the count must not underflow.
    finish = 1'b1;
    tick(10);
    finish = 1'b0;
    chk("underflow_cars", cars, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) pulse_req(k % 4, 60 + k);
    tick(4);
    chk("pre_rst_cars", cars, 5);
    chk("pre_rst_ovf",  overflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_cars",  cars, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_drops", drop_count, 0);
    tick(2);

    // Admission limit.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) pulse_req(k % 4, 70 + k);
    tick(4);
    chk("adm_cars_max", cars, 12);
    chk("adm_blocked",  out_valid, 0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("adm_fin_cars",  cars, 11);
    chk("adm_fin_valid", out_valid, 0);
    tick();
    chk("adm_push_cars", cars, 12);
    chk("adm_push_car",  out_car_id, 82);
    finish = 1'b1;
    tick();
    chk("adm_fin2_cars", cars, 11);
    tick();
    finish = 1'b0;
    chk("adm_both_cars", cars, 11);
    chk("adm_both_car",  out_car_id, 83);
    tick(3);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int mode;
      mode = (c / 250) % 3;
      rst = ($urandom_range(0, 499) == 0);
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 2) == 0) lane_req[n] = ~lane_req[n];
      end
      lane_car_id = {$urandom, $urandom};
      lane_x0     = {$urandom, $urandom};
      lane_v0     = {$urandom, $urandom};
      finish      = ($urandom_range(0, (mode == 2) ? 12 : 3) == 0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = ($urandom_range(0, 7) == 0);
      endcase
      tick();
    end
    rst = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/im_request_queue.md
IM_REQUEST_QUEUE -- requirements
Module: im_request_queue

Interface
REQ-001 Parameter W, default 11, data width of car identity, position, velocity and time fields.
REQ-002 Parameter DEPTH, default 8, FIFO entries (power of two).
REQ-003 Parameter MAX_CARS, default 12, admission limit for vehicles inside the intersection.
REQ-004 clk  in  1  global system clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 lane_req  in  4  per-lane request level from approaching vehicles (lane 0..3).
REQ-007 lane_car_id  in  4*W  packed car identity; lane n at bits [n*W +: W].
REQ-008 lane_x0  in  4*W  packed request position, same packing.
REQ-009 lane_v0  in  4*W  packed request velocity, same packing.
REQ-010 global_time  in  W  external time base.
REQ-011 finish  in  1  one-cycle pulse: a vehicle has left the intersection.
REQ-012 out_valid / out_ready  out / in  1 / 1  request handshake toward the intersection manager.
REQ-013 out_car_id, out_x0, out_v0, out_t0  out  W each  head entry: identity, position, velocity, request timestamp.
REQ-014 out_lane  out  2  lane of head entry.
REQ-015 cars  out  4  vehicles admitted and not yet finished.
REQ-016 overflow  out  1  sticky flag: a lane request was dropped.
REQ-017 drop_count  out  8  dropped-request counter.

Function
REQ-018 Each lane_req bit passes a two-flop register chain; edge[n] = stage1[n] & !stage2[n] (rising edge, 2-cycle latency).
REQ-019 On edge[n] with pending[n]=0: lane n holding register captures car_id, x0, v0 from lane inputs and global_time as t0 in the same cycle; pending[n] <= 1.
REQ-020 On edge[n] with pending[n]=1: new request dropped, holding register unchanged, overflow <= 1, drop_count increments saturating at 255.
REQ-021 Round-robin arbiter grants at most one pending lane per cycle, searching from rr_ptr upward modulo 4; after a grant to lane g, rr_ptr <= g+1 mod 4.
REQ-022 A grant requires: FIFO not full or a pop occurring the same cycle, and cars < MAX_CARS.
REQ-023 Granted lane: entry {lane, car_id, x0, v0, t0} pushed to FIFO; pending[g] <= 0 the same cycle; a new edge on g that same cycle is captured (not dropped).
REQ-024 FIFO first-word-fall-through: out_valid = !empty; out_* show head entry combinationally from storage; pop when out_valid & out_ready.
REQ-025 out_* hold stable while out_valid=1 and out_ready=0.
REQ-026 Pointers are log2(DEPTH)+1 bits; full/empty from MSB/LSB comparison; wrap-around transparent.
REQ-027 cars increments on each push, decrements on finish; push and finish same cycle leaves cars unchanged.
REQ-028 finish with cars=0 is ignored (no underflow); cars never exceeds MAX_CARS by REQ-022.
REQ-029 Pop on empty and push on full-without-pop never occur; storage is untouched in those cases.
REQ-030 Entries wait in lane holding registers while admission or FIFO is blocked; no timeout, no loss.

Reset
REQ-031 rst=1 at a rising edge: both sync stages, pending, rr_ptr, FIFO pointers, cars, overflow, drop_count cleared to 0; out_valid=0.
REQ-032 Reset mid-operation discards all pending and queued entries; FIFO storage and holding registers are not cleared (data outputs are don't-care while out_valid=0).
REQ-033 lane_req held high through reset release produces an edge 2 cycles after release.

Verification
REQ-034 Lane 2 req rises, car_id=5, x0=100, v0=20, global_time=37 at capture, out_ready=1 -> out_valid 3 cycles after input rise with out_lane=2, out_t0=37; cars=1.
REQ-035 All four lanes rise same cycle, rr_ptr=0 -> pushes in order lanes 0,1,2,3 on consecutive cycles; rr_ptr ends at 0.
REQ-036 out_ready=0, 9 requests over time -> 8 queued, 9th stays pending; one pop -> 9th pushed next cycle, full persists.
REQ-037 Lane 1 re-rises while its entry is pending (FIFO full) -> overflow=1, drop_count=1, original entry delivered intact.
REQ-038 cars=12 (MAX_CARS) with lane 0 pending -> no push; finish pulse -> cars=11, push next cycle, cars=12; push+finish same cycle -> cars unchanged.
REQ-039 rst asserted with 5 queued and cars=5 -> next cycle out_valid=0, cars=0, overflow=0, drop_count=0.
